multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM for the multi-cycle RV32I core; successor to the single-cycle decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a req/ready handshake.
//  Drives datapath muxes and enables from the IR fields latched by the datapath.
//  Traps and halts on illegal instructions, ECALL/EBREAK and memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  16  consecutive cycles of mem_req without mem_ready before a timeout trap (>=2)
//  CNT_W        5   timeout counter width; must satisfy 2**CNT_W > MEM_TIMEOUT
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  opcode      in   7  IR[6:0]
//  funct3      in   3  IR[14:12]
//  funct7      in   7  IR[31:25]
//  zero        in   1  rs1==rs2, from branch comparator
//  lt          in   1  rs1<rs2 signed
//  ltu         in   1  rs1<rs2 unsigned
//  mem_ready   in   1  memory accepted/completed the current request
//  mem_req     out  1  memory request, held until mem_ready
//  mem_we      out  1  request is a store
//  ir_we       out  1  latch instruction and old_pc
//  pc_we       out  1  update PC
//  pc_sel      out  2  00 PC+4, 01 old_pc+imm, 10 {alu[31:1],1'b0}
//  rf_we       out  1  register file write
//  alu_a_sel   out  2  00 rs1, 01 old_pc, 10 zero
//  alu_b_sel   out  2  00 rs2, 01 imm
//  alu_ctrl    out  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
//  imm_sel     out  3  0 I, 1 S, 2 B, 3 U, 4 J
//  result_sel  out  2  00 alu, 01 mem rdata, 10 old_pc+4
//  halted      out  1  FSM in TRAP
//  trap_cause  out  2  00 none, 01 illegal, 10 mem timeout, 11 ECALL/EBREAK
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. rst_n low -> IDLE immediately; every
//   output 0 while in reset and in IDLE; trap_cause cleared. IDLE->FETCH next edge.
//  Outputs are combinational from state + IR fields; state, counter and cause are the only flops.
//  FETCH: mem_req=1, mem_we=0. On mem_ready: ir_we=1, pc_we=1, pc_sel=00, ->DECODE.
//  DECODE: one cycle, imm_sel valid; illegal or SYSTEM decode -> TRAP, else ->EXEC.
//   Illegal: unknown opcode; branch funct3 010/011; OP funct7 not 0x00/0x20 (0x20 only
//   with funct3 000/101); OP-IMM shift funct7 not 0x00 (0x20 also legal for funct3 101).
//  EXEC per class, then next state:
//   OP/OP-IMM: alu_b_sel 00/01, alu_ctrl from funct3/funct7[5]; SUB only for OP. ->WB
//   LUI: a=zero, b=imm(U), ADD. AUIPC: a=old_pc, b=imm(U), ADD. ->WB
//   LOAD/STORE: a=rs1, b=imm(I/S), ADD. ->MEM
//   BRANCH: taken = BEQ zero | BNE !zero | BLT lt | BGE !lt | BLTU ltu | BGEU !ltu;
//    taken -> pc_we=1, pc_sel=01. ->FETCH (3 cycles zero-wait)
//   JAL: pc_we=1, pc_sel=01, rf_we=1, result_sel=10. ->FETCH
//   JALR: a=rs1, b=imm(I), ADD, pc_we=1, pc_sel=10, rf_we=1, result_sel=10. ->FETCH
//  MEM: mem_req=1, mem_we=store; ALU controls held as in EXEC. On mem_ready:
//   store ->FETCH (4 cycles); load ->WB (5 cycles).
//  WB: rf_we=1; result_sel 01 for load, else 00; ALU controls held. ->FETCH (ALU: 4 cycles).
//  Timeout: counter cleared on entering FETCH/MEM; +1 each cycle with mem_req & !mem_ready.
//   When it reaches MEM_TIMEOUT-1 with mem_ready low -> TRAP, cause 10.
//   mem_ready in that same cycle wins: normal completion, no trap.
//  TRAP: sticky until reset; all enables and mem_req 0; halted=1; trap_cause held.
//  rf_we with rd=x0 is still driven; the register file ignores it.
//  Reset mid-request: mem_req drops asynchronously; memory discards the transaction.
// CONFIGURATION
//  MC_CTRL_PERF_EN defined: adds outputs instret[31:0] and stall_cycles[31:0].
//   Both reset to 0 and wrap modulo 2**32.
//   instret increments on every transition into FETCH from EXEC, MEM or WB.
//   stall_cycles increments on every cycle with mem_req=1 and mem_ready=0.
//  Undefined: neither port nor counter exists; all other behaviour identical.
// TESTING
//  ADD x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXEC,WB; rf_we only in WB; alu_ctrl=0.
//  LW, mem_ready low 3 cycles per access -> 1+3 FETCH, 1+3 MEM; result_sel=01 in WB; 11 cycles.
//  BGE with lt=0,zero=1 -> pc_we=1,pc_sel=01 in EXEC; same with lt=1 -> pc_we=0; 3 cycles.
//  mem_ready held 0 in FETCH -> TRAP after 16 cycles, halted=1, cause=10.
//   mem_ready=1 on cycle 16 -> DECODE, no trap.
//  opcode 0x7F -> TRAP cause 01; ECALL 0x00000073 -> cause 11; rst_n low -> IDLE, outputs 0.
//  MC_CTRL_PERF_EN, 10 zero-wait ADDs -> instret=10, stall_cycles=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: shared memory port request/ready handshake
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;
  modport master (output mem_req, mem_we, input mem_ready);
  modport slave (input mem_req, mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle control FSM with memory timeout and trap handling
// Define MC_CTRL_PERF_EN to add the instret/stall_cycles performance counters.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  input  logic                   zero,
  input  logic                   lt,
  input  logic                   ltu,
  multicycle_controller_if.master mem,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic [1:0]             pc_sel,
  output logic                   rf_we,
  output logic [1:0]             alu_a_sel,
  output logic [1:0]             alu_b_sel,
  output logic [3:0]             alu_ctrl,
  output logic [2:0]             imm_sel,
  output logic [1:0]             result_sel,
  output logic                   halted,
  output logic [1:0]             trap_cause
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]            instret,
  output logic [31:0]            stall_cycles
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0] cause, cause_n;
  logic is_op, is_opi, is_lui, is_auipc, is_load, is_store, is_br, is_jal, is_jalr, is_sys;
  logic illegal, taken, stall, tmo, in_alu, active, in_exec;
  logic [3:0] alu_op;
  assign is_op    = opcode == 7'b0110011;
  assign is_opi   = opcode == 7'b0010011;
  assign is_lui   = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign is_load  = opcode == 7'b0000011;
  assign is_store = opcode == 7'b0100011;
  assign is_br    = opcode == 7'b1100011;
  assign is_jal   = opcode == 7'b1101111;
  assign is_jalr  = opcode == 7'b1100111;
  assign is_sys   = opcode == 7'b1110011;
  // funct7=0x20 selects SUB/SRA; only funct3 000/101 accept it for OP, only 101 for shift-immediates
  assign illegal = !(is_op | is_opi | is_lui | is_auipc | is_load | is_store | is_br | is_jal | is_jalr | is_sys)
                 | (is_op & !(funct7 == 7'h00 | (funct7 == 7'h20 & (funct3 == 3'b000 | funct3 == 3'b101))))
                 | (is_opi & funct3[1:0] == 2'b01 & !(funct7 == 7'h00 | (funct7 == 7'h20 & funct3 == 3'b101)))
                 | (is_br & funct3[2:1] == 2'b01);
  assign taken = (funct3[2] ? (funct3[1] ? ltu : lt) : zero) ^ funct3[0];
  always_comb begin
    alu_op = 4'd0;
    case (funct3)
      3'b000:  alu_op = (is_op & funct7[5]) ? 4'd1 : 4'd0;
      3'b001:  alu_op = 4'd5;
      3'b010:  alu_op = 4'd8;
      3'b011:  alu_op = 4'd9;
      3'b100:  alu_op = 4'd4;
      3'b101:  alu_op = funct7[5] ? 4'd7 : 4'd6;
      3'b110:  alu_op = 4'd3;
      default: alu_op = 4'd2;
    endcase
  end
  assign stall = mem.mem_req & !mem.mem_ready;
  assign tmo = stall & (cnt == CNT_W'(MEM_TIMEOUT - 1));
  always_comb begin
    state_n = state;
    cause_n = cause;
    case (state)
      IDLE:   state_n = FETCH;
      FETCH: begin
        if (mem.mem_ready) state_n = DECODE;
        else if (tmo) begin
          state_n = TRAP;
          cause_n = 2'b10;
        end
      end
      DECODE: begin
        state_n = (illegal | is_sys) ? TRAP : EXEC;
        cause_n = illegal ? 2'b01 : is_sys ? 2'b11 : cause;
      end
      EXEC:   state_n = (is_load | is_store) ? MEM : (is_op | is_opi | is_lui | is_auipc) ? WB : FETCH;
      MEM: begin
        if (mem.mem_ready) state_n = is_store ? FETCH : WB;
        else if (tmo) begin
          state_n = TRAP;
          cause_n = 2'b10;
        end
      end
      WB:     state_n = FETCH;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cause <= 2'b00;
      cnt <= '0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      cnt <= (state_n != state) ? '0 : stall ? cnt + CNT_W'(1) : cnt;
    end
  end
`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
      stall_cycles <= '0;
    end else begin
      if (state_n == FETCH && state inside {EXEC, MEM, WB}) instret <= instret + 32'd1;
      if (stall) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
  assign in_exec = state == EXEC;
  assign in_alu = state inside {EXEC, MEM, WB};
  assign active = state inside {DECODE, EXEC, MEM, WB};
  assign mem.mem_req = state == FETCH || state == MEM;
  assign mem.mem_we = state == MEM && is_store;
  assign ir_we = state == FETCH && mem.mem_ready;
  assign pc_we = ir_we | (in_exec & (is_jal | is_jalr | (is_br & taken)));
  assign pc_sel = !in_exec ? 2'b00 : is_jalr ? 2'b10 : (is_jal | is_br) ? 2'b01 : 2'b00;
  assign rf_we = state == WB || (in_exec && (is_jal || is_jalr));
  assign result_sel = (state == WB && is_load) ? 2'b01 : (in_exec && (is_jal || is_jalr)) ? 2'b10 : 2'b00;
  assign alu_a_sel = !in_alu ? 2'b00 : is_lui ? 2'b10 : is_auipc ? 2'b01 : 2'b00;
  assign alu_b_sel = (in_alu && (is_opi || is_lui || is_auipc || is_load || is_store || is_jalr)) ? 2'b01 : 2'b00;
  assign alu_ctrl = (in_alu && (is_op || is_opi)) ? alu_op : 4'd0;
  assign imm_sel = !active ? 3'd0 : is_store ? 3'd1 : is_br ? 3'd2 : (is_lui | is_auipc) ? 3'd3 : is_jal ? 3'd4 : 3'd0;
  assign halted = state == TRAP;
  assign trap_cause = cause;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven scoreboard bench for the multi-cycle control FSM
module tb_multicycle_controller;
  typedef struct {
    logic [31:0] ins;
    logic z, l, lu;
    int cyc, rf, rfpos, res, pcwe, pcsel, memwe, imm, alu, a, b;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic ir_we, pc_we, rf_we, halted;
  logic [1:0] pc_sel, alu_a_sel, alu_b_sel, result_sel, trap_cause;
  logic [3:0] alu_ctrl;
  logic [2:0] imm_sel;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instret, stall_cycles;
`endif
  multicycle_controller_if mif();
  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem(mif), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_ctrl(alu_ctrl), .imm_sel(imm_sel), .result_sel(result_sel), .halted(halted),
    .trap_cause(trap_cause)
`ifdef MC_CTRL_PERF_EN
    , .instret(instret), .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int waits = 0, waitc = 0;
  vec_t sb[$];
  localparam logic [31:0] ADD = 32'h002081B3, LW = 32'h00012083;
  function automatic vec_t mk(input logic [31:0] ins, input logic z, l, lu,
                              input int cyc, rf, rfpos, res, pcwe, pcsel, memwe, imm, alu, a, b);
    vec_t v;
    v.ins = ins; v.z = z; v.l = l; v.lu = lu; v.cyc = cyc; v.rf = rf; v.rfpos = rfpos;
    v.res = res; v.pcwe = pcwe; v.pcsel = pcsel; v.memwe = memwe; v.imm = imm;
    v.alu = alu; v.a = a; v.b = b;
    return v;
  endfunction
  function automatic int outs();
    return int'({mif.mem_req, mif.mem_we, ir_we, pc_we, pc_sel, rf_we, alu_a_sel, alu_b_sel,
                 alu_ctrl, imm_sel, result_sel, halted, trap_cause});
  endfunction
  function automatic int enables();
    return int'({mif.mem_req, mif.mem_we, ir_we, pc_we, rf_we});
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // memory answers a request after `waits` low cycles; outputs sampled 1ns after the falling edge
  task automatic step();
    @(negedge clk);
    mif.mem_ready = mif.mem_req && (waitc >= waits);
    #1;
    if (mif.mem_req && !mif.mem_ready) waitc++;
    else waitc = 0;
  endtask
  task automatic load(input logic [31:0] ins);
    opcode = ins[6:0];
    funct3 = ins[14:12];
    funct7 = ins[31:25];
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    mif.mem_ready = 1'b0;
    waitc = 0;
    rst_n = 1'b1;
    #1;
    chk("idle_outputs", outs(), 0);
  endtask
  // entered on an ir_we sample; returns on the next instruction's ir_we sample (or halt)
  task automatic run_one(input vec_t v, input string name);
    vec_t o, e;
    int c;
    load(v.ins);
    zero = v.z; lt = v.l; ltu = v.lu;
    sb.push_back(v);
    o = v;
    o.rf = 0; o.rfpos = -1; o.res = 0; o.pcwe = 0; o.pcsel = 0; o.memwe = 0;
    o.imm = 0; o.alu = 0; o.a = 0; o.b = 0;
    c = 0;
    do begin
      if (c == 1) o.imm = int'(imm_sel);
      if (c == 2) begin
        o.alu = int'(alu_ctrl);
        o.a = int'(alu_a_sel);
        o.b = int'(alu_b_sel);
      end
      if (rf_we) begin
        o.rf++;
        o.rfpos = c;
        o.res = int'(result_sel);
      end
      if (pc_we && !ir_we) begin
        o.pcwe++;
        o.pcsel = int'(pc_sel);
      end
      if (mif.mem_we) o.memwe++;
      c++;
      step();
    end while (!ir_we && !halted && c < 64);
    o.cyc = c;
    e = sb.pop_front();
    chk({name, ".cycles"}, o.cyc, e.cyc);
    chk({name, ".rf_we_count"}, o.rf, e.rf);
    chk({name, ".rf_we_cycle"}, o.rfpos, e.rfpos);
    chk({name, ".result_sel"}, o.res, e.res);
    chk({name, ".pc_we_count"}, o.pcwe, e.pcwe);
    chk({name, ".pc_sel"}, o.pcsel, e.pcsel);
    chk({name, ".mem_we_cycles"}, o.memwe, e.memwe);
    chk({name, ".imm_sel"}, o.imm, e.imm);
    chk({name, ".alu_ctrl"}, o.alu, e.alu);
    chk({name, ".alu_a_sel"}, o.a, e.a);
    chk({name, ".alu_b_sel"}, o.b, e.b);
    chk({name, ".halted"}, int'(halted), 0);
  endtask
  logic [31:0] tins[7] = '{32'h0000007F, 32'h00000073, 32'h00100073, 32'h022080B3,
                           32'h402090B3, 32'h40109093, 32'h0020A063};
  int tcause[7] = '{1, 3, 3, 1, 1, 1, 1};
  initial begin
    vec_t vt[$];
    int n;
    // ins, z, l, lu, cyc, rf, rfpos, res, pcwe, pcsel, memwe, imm, alu, a, b
    vt.push_back(mk(ADD,          0, 0, 0, 4, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(32'h40208133, 0, 0, 0, 4, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(32'h4030D093, 0, 0, 0, 4, 1, 3, 0, 0, 0, 0, 0, 7, 0, 1));
    vt.push_back(mk(32'h0040C093, 0, 0, 0, 4, 1, 3, 0, 0, 0, 0, 0, 4, 0, 1));
    vt.push_back(mk(32'h003130B3, 0, 0, 0, 4, 1, 3, 0, 0, 0, 0, 0, 9, 0, 0));
    vt.push_back(mk(32'h4020D0B3, 0, 0, 0, 4, 1, 3, 0, 0, 0, 0, 0, 7, 0, 0));
    vt.push_back(mk(32'h12345037, 0, 0, 0, 4, 1, 3, 0, 0, 0, 0, 3, 0, 2, 1));
    vt.push_back(mk(32'h00001097, 0, 0, 0, 4, 1, 3, 0, 0, 0, 0, 3, 0, 1, 1));
    vt.push_back(mk(LW,           0, 0, 0, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(32'h00112023, 0, 0, 0, 4, 0, -1, 0, 0, 0, 1, 1, 0, 0, 1));
    vt.push_back(mk(32'h0020D063, 1, 0, 0, 3, 0, -1, 0, 1, 1, 0, 2, 0, 0, 0));
    vt.push_back(mk(32'h0020D063, 1, 1, 0, 3, 0, -1, 0, 0, 0, 0, 2, 0, 0, 0));
    vt.push_back(mk(32'h00208063, 0, 0, 0, 3, 0, -1, 0, 0, 0, 0, 2, 0, 0, 0));
    vt.push_back(mk(32'h00208063, 1, 0, 0, 3, 0, -1, 0, 1, 1, 0, 2, 0, 0, 0));
    vt.push_back(mk(32'h00209063, 1, 0, 0, 3, 0, -1, 0, 0, 0, 0, 2, 0, 0, 0));
    vt.push_back(mk(32'h0020E063, 0, 0, 1, 3, 0, -1, 0, 1, 1, 0, 2, 0, 0, 0));
    vt.push_back(mk(32'h0020F063, 0, 0, 1, 3, 0, -1, 0, 0, 0, 0, 2, 0, 0, 0));
    vt.push_back(mk(32'h008000EF, 0, 0, 0, 3, 1, 2, 2, 1, 1, 0, 4, 0, 0, 0));
    vt.push_back(mk(32'h000100E7, 0, 0, 0, 3, 1, 2, 2, 1, 2, 0, 0, 0, 0, 1));
    mif.mem_ready = 1'b0;
    do_reset();
    waits = 0;
    load(ADD);
    n = 0;
    do begin
      step();
      n++;
    end while (!ir_we && n < 32);
    chk("first_fetch_cycles", n, 1);
    foreach (vt[i]) run_one(vt[i], $sformatf("vec%0d", i));
    // LW with three wait cycles on both the fetch and the data access
    waits = 3;
    run_one(mk(LW, 0, 0, 0, 11, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1), "lw_wait3");
    chk("mem_req_before_reset", int'(mif.mem_req), 1);
    do_reset();
    // fetch never answered: sixteen FETCH cycles then TRAP
    waits = 1000;
    n = 0;
    do begin
      step();
      n++;
    end while (!halted && n < 40);
    chk("fetch_tmo_cycles", n, 17);
    chk("fetch_tmo_cause", int'(trap_cause), 2);
    chk("fetch_tmo_enables", enables(), 0);
    repeat (3) step();
    chk("trap_sticky_halted", int'(halted), 1);
    chk("trap_sticky_cause", int'(trap_cause), 2);
    // mem_ready on the sixteenth cycle completes normally
    do_reset();
    waits = 15;
    load(ADD);
    n = 0;
    do begin
      step();
      n++;
    end while (!ir_we && !halted && n < 40);
    chk("late_ready_cycles", n, 16);
    repeat (2) step();
    chk("late_ready_halted", int'(halted), 0);
    chk("late_ready_cause", int'(trap_cause), 0);
    // data access never answered
    do_reset();
    waits = 0;
    load(LW);
    step();
    n = 1;
    waits = 1000;
    do begin
      step();
      n++;
    end while (!halted && n < 60);
    chk("mem_tmo_cycles", n, 20);
    chk("mem_tmo_cause", int'(trap_cause), 2);
    foreach (tins[i]) begin
      do_reset();
      waits = 0;
      load(tins[i]);
      n = 0;
      do begin
        step();
        n++;
      end while (!halted && n < 20);
      chk($sformatf("trap%0d.cycles", i), n, 3);
      chk($sformatf("trap%0d.cause", i), int'(trap_cause), tcause[i]);
      chk($sformatf("trap%0d.enables", i), enables(), 0);
    end
`ifdef MC_CTRL_PERF_EN
    do_reset();
    waits = 0;
    load(ADD);
    n = 0;
    do begin
      step();
      n++;
    end while (!ir_we && n < 32);
    repeat (10) run_one(vt[0], "perf_add");
    chk("instret", int'(instret), 10);
    chk("stall_cycles", int'(stall_cycles), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
